alu_arbiter: RTL and testbench

- Shares one registered 16-bit ALU core between two requesters (req0, req1) using valid/ready handshakes and round-robin arbitration.
- Latches the winning operation and holds the ALU inputs stable for the ALU latency, then captures the result and derives zero/negative flags.
- Returns the response only to the granted requester and holds it until that requester accepts it.
- Sits between the instruction-issue logic and the ALU core. Drives the core's op/dataA/dataB inputs and its active-low reset.

---
 rtl/alu_arbiter_if.sv | 29 ++
 rtl/alu_arbiter.sv | 95 +++++++++
 tb/tb_alu_arbiter.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_if.sv
// Request/response handshake bundle between the two requesters and alu_arbiter.
interface alu_arbiter_if #(
  parameter int WIDTH = 16,
  parameter int OPW   = 4
);
  logic             req0_valid, req0_ready;
  logic [OPW-1:0]   req0_op;
  logic [WIDTH-1:0] req0_a, req0_b;
  logic             req1_valid, req1_ready;
  logic [OPW-1:0]   req1_op;
  logic [WIDTH-1:0] req1_a, req1_b;
  logic             resp0_valid, resp1_valid, resp_ready;
  logic [WIDTH-1:0] resp_data;
  logic             resp_zero, resp_neg;

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b, resp_ready,
    output req0_ready, req1_ready, resp0_valid, resp1_valid,
    output resp_data, resp_zero, resp_neg
  );

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b, resp_ready,
    input  req0_ready, req1_ready, resp0_valid, resp1_valid,
    input  resp_data, resp_zero, resp_neg
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one registered ALU core between two requesters;
// holds ALU inputs for ALU_LAT cycles, then returns the result to the winner.
module alu_arbiter #(
  parameter int WIDTH   = 16,
  parameter int OPW     = 4,
  parameter int ALU_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  alu_arbiter_if.slave     bus,
  output logic             busy,
  output logic             alu_rst_n,
  output logic [OPW-1:0]   alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_result
);
  localparam int LCW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state;
  logic             prio;
  logic             grant;
  logic [LCW-1:0]   lat_cnt;
  logic             rv0, rv1;
  logic [WIDTH-1:0] rdata;
  logic             rzero, rneg;
  logic             sel1, take;

  // prio=1 prefers requester 1; ready is suppressed during reset
  assign sel1 = bus.req1_valid & (~bus.req0_valid | prio);
  assign take = (state == IDLE) & ~rst & (bus.req0_valid | bus.req1_valid);

  assign bus.req0_ready  = take & ~sel1;
  assign bus.req1_ready  = take & sel1;
  assign bus.resp0_valid = rv0;
  assign bus.resp1_valid = rv1;
  assign bus.resp_data   = rdata;
  assign bus.resp_zero   = rzero;
  assign bus.resp_neg    = rneg;
  assign busy            = (state != IDLE);
  assign alu_rst_n       = ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      prio    <= 1'b0;
      grant   <= 1'b0;
      lat_cnt <= '0;
      alu_op  <= '0;
      alu_a   <= '0;
      alu_b   <= '0;
      rdata   <= '0;
      rzero   <= 1'b0;
      rneg    <= 1'b0;
      rv0     <= 1'b0;
      rv1     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (take) begin
            alu_op  <= sel1 ? bus.req1_op : bus.req0_op;
            alu_a   <= sel1 ? bus.req1_a  : bus.req0_a;
            alu_b   <= sel1 ? bus.req1_b  : bus.req0_b;
            grant   <= sel1;
            lat_cnt <= LCW'(ALU_LAT - 1);
            state   <= EXEC;
          end
        end
        EXEC: begin
          if (lat_cnt == '0) begin
            rdata <= alu_result;
            rzero <= (alu_result == '0);
            rneg  <= alu_result[WIDTH-1];
            rv0   <= ~grant;
            rv1   <= grant;
            state <= RESP;
          end else begin
            lat_cnt <= lat_cnt - LCW'(1);
          end
        end
        RESP: begin
          if (bus.resp_ready) begin
            rv0   <= 1'b0;
            rv1   <= 1'b0;
            prio  <= ~grant;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: ALU_LAT=1 instance (vectors, contention,
// backpressure, mid-EXEC reset) and an ALU_LAT=3 instance.
module tb_alu_arbiter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_arbiter_if #(.WIDTH(16), .OPW(4)) b1();
  alu_arbiter_if #(.WIDTH(16), .OPW(4)) b3();

  logic        busy1, arn1, busy3, arn3;
  logic [3:0]  op1, op3;
  logic [15:0] a1, bb1, res1, a3, bb3, res3;

  alu_arbiter #(.WIDTH(16), .OPW(4), .ALU_LAT(1)) u1 (
    .clk(clk), .rst(rst), .bus(b1), .busy(busy1), .alu_rst_n(arn1),
    .alu_op(op1), .alu_a(a1), .alu_b(bb1), .alu_result(res1));

  alu_arbiter #(.WIDTH(16), .OPW(4), .ALU_LAT(3)) u3 (
    .clk(clk), .rst(rst), .bus(b3), .busy(busy3), .alu_rst_n(arn3),
    .alu_op(op3), .alu_a(a3), .alu_b(bb3), .alu_result(res3));

  function automatic logic [15:0] alu_f(input logic [3:0] op, input logic [15:0] a, b);
    case (op)
      4'd0: alu_f = a + b;
      4'd1: alu_f = a - b;
      4'd2: alu_f = a & b;
      4'd3: alu_f = a | b;
      4'd4: alu_f = a ^ b;
      4'd5: alu_f = a << b[3:0];
      4'd6: alu_f = a >> b[3:0];
      default: alu_f = a;
    endcase
  endfunction

  // The arbiter's alu_* registers are the first ALU stage, so the core
  // model adds ALU_LAT-1 further register stages.
  assign res1 = arn1 ? alu_f(op1, a1, bb1) : 16'h0000;
  logic [15:0] p1, p2;
  always @(posedge clk) begin
    if (!arn3) begin
      p1 <= '0;
      p2 <= '0;
    end else begin
      p1 <= alu_f(op3, a3, bb3);
      p2 <= p1;
    end
  end
  assign res3 = p2;

  typedef struct {
    bit          r;
    logic [3:0]  op;
    logic [15:0] a, b, exp;
    bit          z, n;
  } vec_t;

  vec_t vt[8];
  int unsigned nvec = 0;
  int unsigned nerr = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    b1.req0_valid = 0; b1.req1_valid = 0; b1.resp_ready = 0;
    b1.req0_op = '0; b1.req0_a = '0; b1.req0_b = '0;
    b1.req1_op = '0; b1.req1_a = '0; b1.req1_b = '0;
    b3.req0_valid = 0; b3.req1_valid = 0; b3.resp_ready = 0;
    b3.req0_op = '0; b3.req0_a = '0; b3.req0_b = '0;
    b3.req1_op = '0; b3.req1_a = '0; b3.req1_b = '0;
  endtask

  // Single-requester transaction on the ALU_LAT=1 instance, immediate resp_ready.
  task automatic run_txn(input vec_t v, input int idx);
    string t;
    t = $sformatf("vec%0d", idx);
    b1.resp_ready = 1;
    if (v.r) begin
      b1.req1_valid = 1; b1.req1_op = v.op; b1.req1_a = v.a; b1.req1_b = v.b;
    end else begin
      b1.req0_valid = 1; b1.req0_op = v.op; b1.req0_a = v.a; b1.req0_b = v.b;
    end
    #1;
    chk({t, ".ready_own"},   v.r ? b1.req1_ready : b1.req0_ready, 1);
    chk({t, ".ready_other"}, v.r ? b1.req0_ready : b1.req1_ready, 0);
    step();
    b1.req0_valid = 0; b1.req1_valid = 0;
    chk({t, ".exec_busy"}, busy1, 1);
    chk({t, ".exec_rv"}, {b1.resp0_valid, b1.resp1_valid}, 0);
    step();
    chk({t, ".rv_own"},   v.r ? b1.resp1_valid : b1.resp0_valid, 1);
    chk({t, ".rv_other"}, v.r ? b1.resp0_valid : b1.resp1_valid, 0);
    chk({t, ".data"}, b1.resp_data, v.exp);
    chk({t, ".flags"}, {b1.resp_zero, b1.resp_neg}, {v.z, v.n});
    step();
    chk({t, ".back_idle"}, {busy1, b1.resp0_valid, b1.resp1_valid}, 0);
  endtask

  initial begin
    vt[0] = '{0, 4'h0, 16'h0003, 16'h0005, 16'h0008, 0, 0};
    vt[1] = '{1, 4'h0, 16'hFFFF, 16'h0001, 16'h0000, 1, 0};
    vt[2] = '{0, 4'h1, 16'h0000, 16'h0001, 16'hFFFF, 0, 1};
    vt[3] = '{1, 4'h2, 16'hF0F0, 16'hFF00, 16'hF000, 0, 1};
    vt[4] = '{0, 4'h4, 16'h5A5A, 16'h5A5A, 16'h0000, 1, 0};
    vt[5] = '{1, 4'h5, 16'h0001, 16'h000F, 16'h8000, 0, 1};
    vt[6] = '{0, 4'h6, 16'h8000, 16'h0004, 16'h0800, 0, 0};
    vt[7] = '{1, 4'hF, 16'h1234, 16'hFFFF, 16'h1234, 0, 0};

    // Reset with both requesters valid; contention operands preloaded
    idle_inputs();
    rst = 1;
    b1.req0_valid = 1; b1.req0_op = 4'h1; b1.req0_a = 16'h0005; b1.req0_b = 16'h0005;
    b1.req1_valid = 1; b1.req1_op = 4'h1; b1.req1_a = 16'h0000; b1.req1_b = 16'h0001;
    step();
    step();
    chk("rst.ready", {b1.req0_ready, b1.req1_ready}, 0);
    chk("rst.rv", {b1.resp0_valid, b1.resp1_valid}, 0);
    chk("rst.busy", busy1, 0);
    chk("rst.alu_in", {op1, a1, bb1}, 0);
    chk("rst.alu_rst_n", arn1, 0);
    chk("rst.resp", {b1.resp_data, b1.resp_zero, b1.resp_neg}, 0);
    rst = 0;
    b1.resp_ready = 1;
    #1;
    chk("rst.alu_rst_n_rel", arn1, 1);

    // Contention: grants alternate 0,1,0
    for (int k = 0; k < 3; k++) begin
      bit g;
      g = (k % 2) == 1;
      chk($sformatf("cont%0d.ready", k), {b1.req1_ready, b1.req0_ready}, g ? 2'b10 : 2'b01);
      step();
      chk($sformatf("cont%0d.exec_ready", k), {b1.req1_ready, b1.req0_ready}, 0);
      step();
      chk($sformatf("cont%0d.rv", k), {b1.resp1_valid, b1.resp0_valid}, g ? 2'b10 : 2'b01);
      chk($sformatf("cont%0d.data", k), b1.resp_data, g ? 16'hFFFF : 16'h0000);
      chk($sformatf("cont%0d.flags", k), {b1.resp_zero, b1.resp_neg}, g ? 2'b01 : 2'b10);
      if (k == 2) begin
        b1.req0_valid = 0; b1.req1_valid = 0;
      end
      step();
    end

    // Backpressure: prio now favours req1, but only req0 is presented
    b1.resp_ready = 0;
    b1.req0_valid = 1; b1.req0_op = 4'h0; b1.req0_a = 16'h1000; b1.req0_b = 16'h0234;
    #1;
    chk("bp.accept0", b1.req0_ready, 1);
    step();
    b1.req0_valid = 0;
    b1.req1_valid = 1; b1.req1_op = 4'h3; b1.req1_a = 16'h00F0; b1.req1_b = 16'h0F00;
    step();
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("bp%0d.hold", c),
          {b1.resp0_valid, b1.resp1_valid, b1.resp_data, b1.req1_ready, busy1},
          {1'b1, 1'b0, 16'h1234, 1'b0, 1'b1});
      if (c == 4) b1.resp_ready = 1;
      else step();
    end
    step();
    chk("bp.accept1", {b1.req1_ready, b1.req0_ready}, 2'b10);
    step();
    b1.req1_valid = 0;
    step();
    chk("bp.resp1", {b1.resp1_valid, b1.resp_data}, {1'b1, 16'h0FF0});
    step();

    foreach (vt[i]) run_txn(vt[i], i);

    // Mid-EXEC reset: leave prio=1 first so the reset-forced prio=0 is visible
    run_txn('{0, 4'h0, 16'h0001, 16'h0001, 16'h0002, 0, 0}, 99);
    b1.req1_valid = 1; b1.req1_op = 4'h0; b1.req1_a = 16'h0007; b1.req1_b = 16'h0007;
    #1;
    chk("mrst.accept1", b1.req1_ready, 1);
    step();
    b1.req1_valid = 0;
    chk("mrst.in_exec", busy1, 1);
    rst = 1;
    step();
    chk("mrst.idle", {busy1, b1.resp0_valid, b1.resp1_valid}, 0);
    chk("mrst.alu_in", {op1, a1, bb1}, 0);
    rst = 0;
    for (int c = 0; c < 3; c++) begin
      step();
      chk($sformatf("mrst.norv%0d", c), {b1.resp0_valid, b1.resp1_valid, busy1}, 0);
    end
    b1.req0_valid = 1; b1.req0_op = 4'h0; b1.req0_a = 16'h0002; b1.req0_b = 16'h0002;
    b1.req1_valid = 1; b1.req1_op = 4'h0; b1.req1_a = 16'h0009; b1.req1_b = 16'h0009;
    #1;
    chk("mrst.prio0", {b1.req1_ready, b1.req0_ready}, 2'b01);
    step();
    b1.req0_valid = 0; b1.req1_valid = 0;
    step();
    chk("mrst.resp0", {b1.resp0_valid, b1.resp1_valid, b1.resp_data}, {2'b10, 16'h0004});
    step();

    // ALU_LAT=3 instance: SLL 1<<4 on requester 1
    b3.resp_ready = 1;
    b3.req1_valid = 1; b3.req1_op = 4'h5; b3.req1_a = 16'h0001; b3.req1_b = 16'h0004;
    #1;
    chk("lat3.accept", {b3.req1_ready, b3.req0_ready}, 2'b10);
    step();
    b3.req1_valid = 0;
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("lat3.exec%0d", c),
          {busy3, b3.resp1_valid, op3, a3, bb3},
          {1'b1, 1'b0, 4'h5, 16'h0001, 16'h0004});
      step();
    end
    chk("lat3.rv", {b3.resp1_valid, b3.resp0_valid}, 2'b10);
    chk("lat3.data", {b3.resp_data, b3.resp_zero, b3.resp_neg}, {16'h0010, 2'b00});
    step();
    chk("lat3.idle", {busy3, b3.resp1_valid}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
